// File: rtl/led_scan_seq_pkg.sv
// Shared constants and types for the LED scan sequencer.
package led_scan_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_scan_seq_if.sv
// Control and position signals between the sequencer and its driver.
// No valid/ready handshake: en/mode/step are levels sampled on every rising
// sys_clk; sel_out/tick/wrap are registered and valid every cycle.
interface led_scan_seq_if;
  logic       en;
  logic [1:0] mode;
  logic       step;
  logic [2:0] sel_out;
  logic       tick;
  logic       wrap;

  modport master (output en, mode, step, input sel_out, tick, wrap);
  modport slave  (input en, mode, step, output sel_out, tick, wrap);
endinterface

// File: rtl/led_scan_seq_tick_gen.sv
// Prescaler: pulses adv_auto once every CNT_MAX+1 enabled clocks.
module tick_gen #(
  parameter int CNT_MAX = 24_999_999,
  parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic adv_auto
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max   = (cnt_q == CNT_W'(CNT_MAX));
  // Gated by en so dropping en at terminal count holds cnt at CNT_MAX.
  assign adv_auto = en & at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_scan_seq.sv
// 3-bit position sequencer for the LED decoder: prescaled auto-advance or
// single-step, walking up, down, ping-pong or holding.
module led_scan_seq
  import led_scan_pkg::*;
#(
  parameter int CNT_MAX = 24_999_999,
  parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  led_scan_seq_if.slave       bus,
  output dir_e                dir_o
);

  logic       adv_auto;
  logic       adv_step;
  logic       adv;
  logic       step_q;
  logic [2:0] sel_q;
  logic       tick_q;
  logic       wrap_q;
  dir_e       dir_q;

  tick_gen #(
    .CNT_MAX (CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_tick_gen (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (bus.en),
    .adv_auto (adv_auto)
  );

  // step_q resets high so a step held through reset is not seen as an edge.
  assign adv_step = bus.step & ~step_q & ~bus.en;
  assign adv      = (adv_auto | adv_step) & (bus.mode != MODE_HOLD);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel_q  <= 3'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      step_q <= 1'b1;
      dir_q  <= DIR_UP;
    end else begin
      step_q <= bus.step;
      tick_q <= adv;
      wrap_q <= 1'b0;
      if (adv) begin
        case (bus.mode)
          MODE_UP: begin
            dir_q  <= DIR_UP;
            sel_q  <= sel_q + 3'd1;
            wrap_q <= (sel_q == 3'd7);
          end
          MODE_DOWN: begin
            dir_q  <= DIR_DOWN;
            sel_q  <= sel_q - 3'd1;
            wrap_q <= (sel_q == 3'd0);
          end
          MODE_PP: begin
            if (dir_q == DIR_UP) begin
              if (sel_q == 3'd7) begin
                sel_q  <= 3'd6;
                dir_q  <= DIR_DOWN;
                wrap_q <= 1'b1;
              end else begin
                sel_q <= sel_q + 3'd1;
              end
            end else begin
              if (sel_q == 3'd0) begin
                sel_q  <= 3'd1;
                dir_q  <= DIR_UP;
                wrap_q <= 1'b1;
              end else begin
                sel_q <= sel_q - 3'd1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.sel_out = sel_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign dir_o       = dir_q;

endmodule
